sdio_cmd_engine: RTL and testbench

SD/SDIO command-line engine for the uDMA SDIO peripheral. Sits directly downstream of the SDIO register interface. It consumes the start pulse and the command opcode, argument, response type and data timeout. It serialises the 48-bit command frame on CMD, then receives, checks and stores the card response. It returns the response words, status and the one-cycle eot/err pulses that the register interface latches.

---
 rtl/sdio_pkg.sv | 50 +++++
 rtl/sdio_crc7.sv | 44 ++++
 rtl/sdio_cmd_engine.sv | 268 ++++++++++++++++++++++++++
 tb/tb_sdio_cmd_engine.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdio_pkg.sv
// Shared definitions for the SDIO command-line engine: response type codes,
// FSM state encoding, status bit positions and the CRC7 helper.
package sdio_pkg;

    // Response type codes as presented on rsp_type_i
    localparam logic [2:0] RSP_NONE     = 3'd0;
    localparam logic [2:0] RSP_48_CRC   = 3'd1;
    localparam logic [2:0] RSP_48_NOCRC = 3'd2;
    localparam logic [2:0] RSP_136      = 3'd3;
    localparam logic [2:0] RSP_48_BUSY  = 3'd4;

    // Status bit positions inside status_o
    localparam int unsigned STAT_TIMEOUT = 0;
    localparam int unsigned STAT_CRC     = 1;
    localparam int unsigned STAT_END     = 2;
    localparam int unsigned STAT_BUSY_TO = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX      = 3'd1,
        ST_TURN    = 3'd2,
        ST_RX_WAIT = 3'd3,
        ST_RX      = 3'd4,
        ST_BUSY    = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    // One serial step of CRC7, polynomial x^7 + x^3 + 1, MSB first
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Debug view of the state. DONE lasts a single cycle and is shown with no bit set.
    function automatic logic [5:0] state_onehot(input state_e s);
        logic [5:0] oh;
        case (s)
            ST_IDLE:    oh = 6'b000001;
            ST_TX:      oh = 6'b000010;
            ST_TURN:    oh = 6'b000100;
            ST_RX_WAIT: oh = 6'b001000;
            ST_RX:      oh = 6'b010000;
            ST_BUSY:    oh = 6'b100000;
            default:    oh = 6'b000000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/sdio_crc7.sv
// Serial CRC7 accumulator. A clear together with an enable restarts the
// CRC and absorbs the current bit in the same cycle.
module sdio_crc7
    import sdio_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       dat_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;

    // Next CRC value: restart, advance or hold
    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            if (en_i) begin
                crc_d = crc7_step(7'h00, dat_i);
            end else begin
                crc_d = 7'h00;
            end
        end else if (en_i) begin
            crc_d = crc7_step(crc_q, dat_i);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sdio_cmd_engine.sv
// SD/SDIO command-line engine: sends the 48-bit command frame, collects and
// checks the card response, handles R1b busy and reports completion.
module sdio_cmd_engine
    import sdio_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         start_i,
    input  logic [5:0]   cmd_op_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [2:0]   rsp_type_i,
    input  logic [19:0]  busy_timeout_i,
    input  logic         sddat0_i,
    input  logic         sdcmd_i,
    output logic         sdcmd_o,
    output logic         sdcmd_oen_o,
    output logic [127:0] rsp_data_o,
    output logic [15:0]  status_o,
    output logic         eot_o,
    output logic         err_o,
    output logic         busy_o,
    output logic [5:0]   dbg_state_o
);

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [19:0]    wcnt_q, wcnt_d;
    logic [2:0]     typ_q, typ_d;
    logic [39:0]    frame_q, frame_d;
    logic [126:0]   rx_sr_q, rx_sr_d;
    logic           sdcmd_q, sdcmd_d;
    logic           oen_q, oen_d;
    logic [127:0]   rsp_q, rsp_d;
    logic [15:0]    status_q, status_d;
    logic           eot_q, eot_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic [5:0]     dbg_q, dbg_d;

    logic           tx_clr_s, tx_en_s, tx_bit_s;
    logic           rx_clr_s, rx_en_s;
    logic [6:0]     tx_crc_s, rx_crc_s;
    logic [127:0]   rx_full_s;
    logic           is_r136_s;
    logic           rx_last_s;
    logic           crc_bad_s;

    sdio_crc7 u_crc_tx (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (tx_clr_s),
        .en_i   (tx_en_s),
        .dat_i  (tx_bit_s),
        .crc_o  (tx_crc_s)
    );

    sdio_crc7 u_crc_rx (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (rx_clr_s),
        .en_i   (rx_en_s),
        .dat_i  (sdcmd_i),
        .crc_o  (rx_crc_s)
    );

    // Next-state, counters, datapath and registered output values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        typ_d     = typ_q;
        frame_d   = frame_q;
        rx_sr_d   = rx_sr_q;
        sdcmd_d   = sdcmd_q;
        oen_d     = oen_q;
        rsp_d     = rsp_q;
        status_d  = status_q;
        eot_d     = 1'b0;
        err_d     = 1'b0;
        tx_clr_s  = 1'b0;
        tx_en_s   = 1'b0;
        tx_bit_s  = frame_q[39];
        rx_clr_s  = 1'b0;
        rx_en_s   = 1'b0;
        crc_bad_s = 1'b0;
        rx_full_s = {rx_sr_q, sdcmd_i};
        is_r136_s = (typ_q == RSP_136);
        rx_last_s = is_r136_s ? (cnt_q == 8'd135) : (cnt_q == 8'd47);

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    typ_d    = (rsp_type_i > RSP_48_BUSY) ? RSP_NONE : rsp_type_i;
                    // Bits 46..8 of the frame, left-aligned; bit 47 goes out now
                    frame_d  = {1'b1, cmd_op_i, cmd_arg_i, 1'b0};
                    cnt_d    = 8'd1;
                    tx_clr_s = 1'b1;
                    tx_en_s  = 1'b1;
                    tx_bit_s = 1'b0;
                    sdcmd_d  = 1'b0;
                    oen_d    = 1'b0;
                    rsp_d    = 128'h0;
                    status_d = 16'h0000;
                    state_d  = ST_TX;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_TX: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd40) begin
                    // CRC is complete: send its MSB, queue the rest plus end bit
                    sdcmd_d = tx_crc_s[6];
                    frame_d = {tx_crc_s[5:0], 1'b1, 33'h0};
                end else if (cnt_q < 8'd48) begin
                    sdcmd_d = frame_q[39];
                    frame_d = {frame_q[38:0], 1'b0};
                    tx_en_s = (cnt_q < 8'd40);
                end else begin
                    sdcmd_d = 1'b1;
                    oen_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = (typ_q == RSP_NONE) ? ST_DONE : ST_TURN;
                end
            end

            ST_TURN: begin
                if (cnt_q == 8'd1) begin
                    cnt_d   = 8'd0;
                    wcnt_d  = 20'd0;
                    state_d = ST_RX_WAIT;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end

            ST_RX_WAIT: begin
                // A start bit wins over an expiring timeout in the same cycle
                if (!sdcmd_i) begin
                    cnt_d    = 8'd1;
                    rx_sr_d  = 127'h0;
                    rx_clr_s = 1'b1;
                    rx_en_s  = !is_r136_s;
                    state_d  = ST_RX;
                end else if (wcnt_q == 20'(RSP_TIMEOUT - 1)) begin
                    status_d[STAT_TIMEOUT] = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    wcnt_d   = wcnt_q + 20'd1;
                end
            end

            ST_RX: begin
                rx_sr_d = rx_full_s[126:0];
                cnt_d   = cnt_q + 8'd1;
                if (is_r136_s) begin
                    rx_en_s = (cnt_q >= 8'd8) && (cnt_q < 8'd128);
                end else begin
                    rx_en_s = (cnt_q < 8'd40);
                end
                if (rx_last_s) begin
                    // rx_sr_q[6:0] holds response bits 7..1 at this point
                    crc_bad_s = (typ_q != RSP_48_NOCRC) && (rx_crc_s != rx_sr_q[6:0]);
                    status_d[STAT_CRC] = crc_bad_s;
                    status_d[STAT_END] = !sdcmd_i;
                    status_d[13:8]     = rx_full_s[45:40];
                    rsp_d   = is_r136_s ? rx_full_s : {96'h0, rx_full_s[39:8]};
                    cnt_d   = 8'd0;
                    wcnt_d  = 20'd0;
                    if ((typ_q == RSP_48_BUSY) && !crc_bad_s && sdcmd_i) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_RX;
                end
            end

            ST_BUSY: begin
                // Give the card two cycles to pull DAT0 low before sensing it
                if (cnt_q < 8'd2) begin
                    cnt_d   = cnt_q + 8'd1;
                end else if (sddat0_i) begin
                    state_d = ST_DONE;
                end else if ((busy_timeout_i != 20'd0) && (wcnt_q == busy_timeout_i - 20'd1)) begin
                    status_d[STAT_BUSY_TO] = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wcnt_d  = wcnt_q + 20'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion pulse is issued as the engine enters DONE
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            if (|status_d[3:0]) begin
                err_d = 1'b1;
                eot_d = 1'b0;
            end else begin
                eot_d = 1'b1;
                err_d = 1'b0;
            end
        end else begin
            eot_d = 1'b0;
            err_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
        dbg_d  = state_onehot(state_d);
    end

    // State, counters, datapath and output registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            wcnt_q   <= 20'd0;
            typ_q    <= RSP_NONE;
            frame_q  <= 40'h0;
            rx_sr_q  <= 127'h0;
            sdcmd_q  <= 1'b1;
            oen_q    <= 1'b1;
            rsp_q    <= 128'h0;
            status_q <= 16'h0000;
            eot_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            dbg_q    <= 6'b000001;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            typ_q    <= typ_d;
            frame_q  <= frame_d;
            rx_sr_q  <= rx_sr_d;
            sdcmd_q  <= sdcmd_d;
            oen_q    <= oen_d;
            rsp_q    <= rsp_d;
            status_q <= status_d;
            eot_q    <= eot_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            dbg_q    <= dbg_d;
        end
    end

    assign sdcmd_o     = sdcmd_q;
    assign sdcmd_oen_o = oen_q;
    assign rsp_data_o  = rsp_q;
    assign status_o    = status_q;
    assign eot_o       = eot_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign dbg_state_o = dbg_q;

endmodule

// File: tb/tb_sdio_cmd_engine.sv
// Directed bench for sdio_cmd_engine: command framing, response checking,
// timeouts, R2, R1b busy, ignored restart and asynchronous reset.
module tb_sdio_cmd_engine;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic         start_i;
    logic [5:0]   cmd_op_i;
    logic [31:0]  cmd_arg_i;
    logic [2:0]   rsp_type_i;
    logic [19:0]  busy_timeout_i;
    logic         sddat0_i;
    logic         sdcmd_i;
    logic         sdcmd_o;
    logic         sdcmd_oen_o;
    logic [127:0] rsp_data_o;
    logic [15:0]  status_o;
    logic         eot_o;
    logic         err_o;
    logic         busy_o;
    logic [5:0]   dbg_state_o;

    int n_cmp = 0;
    int n_err = 0;

    sdio_cmd_engine #(.RSP_TIMEOUT(64)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .start_i        (start_i),
        .cmd_op_i       (cmd_op_i),
        .cmd_arg_i      (cmd_arg_i),
        .rsp_type_i     (rsp_type_i),
        .busy_timeout_i (busy_timeout_i),
        .sddat0_i       (sddat0_i),
        .sdcmd_i        (sdcmd_i),
        .sdcmd_o        (sdcmd_o),
        .sdcmd_oen_o    (sdcmd_oen_o),
        .rsp_data_o     (rsp_data_o),
        .status_o       (status_o),
        .eot_o          (eot_o),
        .err_o          (err_o),
        .busy_o         (busy_o),
        .dbg_state_o    (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference CRC7 over v[n-1:0], MSB first
    function automatic logic [6:0] tb_crc7(input logic [127:0] v, input int n);
        logic [6:0] c;
        logic fb;
        c = 7'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = v[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // Pulse start and capture the 48 CMD bits of cycles 1..48; returns at cycle 49
    task automatic issue(input logic [5:0] op, input logic [31:0] arg, input logic [2:0] typ,
                         input logic [19:0] bto, output logic [47:0] fr, output logic oen_ok);
        @(negedge clk_i);
        cmd_op_i = op; cmd_arg_i = arg; rsp_type_i = typ; busy_timeout_i = bto;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        oen_ok = 1'b1;
        for (int i = 0; i < 48; i++) begin
            fr[47 - i] = sdcmd_o;
            if (sdcmd_oen_o !== 1'b0) oen_ok = 1'b0;
            @(negedge clk_i);
        end
    endtask

    // Card reply: start bit driven at cycle 51, one bit per cycle
    task automatic send_resp(input logic [135:0] bits, input int len);
        @(negedge clk_i);
        @(negedge clk_i);
        for (int i = 0; i < len; i++) begin
            sdcmd_i = bits[len - 1 - i];
            @(negedge clk_i);
        end
        sdcmd_i = 1'b1;
    endtask

    // Wait (bounded) for eot_o or err_o
    task automatic wait_pulse(input int max, output logic ge, output logic gr);
        int w;
        w = 0;
        while (!eot_o && !err_o && w < max) begin
            @(negedge clk_i);
            w++;
        end
        ge = eot_o;
        gr = err_o;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        n_cmp++; if (sdcmd_o !== 1'b1 || sdcmd_oen_o !== 1'b1) begin n_err++; $display("FAIL reset_cmd: got %b/%b want 1/1", sdcmd_o, sdcmd_oen_o); end
        n_cmp++; if (rsp_data_o !== 128'h0 || status_o !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h/%h want 0/0", rsp_data_o, status_o); end
        n_cmp++; if ({eot_o, err_o, busy_o} !== 3'b000 || dbg_state_o !== 6'b000001) begin n_err++; $display("FAIL reset_ctl: got %b dbg %b want 000 dbg 000001", {eot_o, err_o, busy_o}, dbg_state_o); end
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_cmd0();
        logic [47:0] fr;
        logic ok;
        issue(6'd0, 32'h0, 3'd0, 20'd0, fr, ok);
        n_cmp++; if (fr !== 48'h40_00000000_95) begin n_err++; $display("FAIL cmd0_frame: got %h want 400000000095", fr); end
        n_cmp++; if (ok !== 1'b1 || sdcmd_oen_o !== 1'b1) begin n_err++; $display("FAIL cmd0_oen: got drive_ok=%b oen49=%b want 1 1", ok, sdcmd_oen_o); end
        n_cmp++; if ({eot_o, err_o, busy_o} !== 3'b101 || status_o !== 16'h0) begin n_err++; $display("FAIL cmd0_eot49: got eot/err/busy %b status %h want 101 0000", {eot_o, err_o, busy_o}, status_o); end
        @(negedge clk_i);
        n_cmp++; if ({eot_o, busy_o} !== 2'b00 || dbg_state_o !== 6'b000001) begin n_err++; $display("FAIL cmd0_after: got eot/busy %b dbg %b want 00 000001", {eot_o, busy_o}, dbg_state_o); end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_cmd8();
        logic [47:0] fr;
        logic ok, ge, gr;
        issue(6'd8, 32'h0000_01AA, 3'd1, 20'd0, fr, ok);
        n_cmp++; if (fr !== 48'h48_000001AA_87) begin n_err++; $display("FAIL cmd8_frame: got %h want 48000001aa87", fr); end
        send_resp({88'h0, 48'h08_000001AA_13}, 48);
        wait_pulse(10, ge, gr);
        n_cmp++; if ({ge, gr} !== 2'b10) begin n_err++; $display("FAIL cmd8_eot: got eot/err %b want 10", {ge, gr}); end
        n_cmp++; if (rsp_data_o !== 128'h1AA) begin n_err++; $display("FAIL cmd8_rsp: got %h want 1aa", rsp_data_o); end
        n_cmp++; if (status_o !== 16'h0800) begin n_err++; $display("FAIL cmd8_status: got %h want 0800", status_o); end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_rsp_timeout();
        logic [47:0] fr;
        logic ok;
        issue(6'd55, 32'h0, 3'd1, 20'd0, fr, ok);
        repeat (65) @(negedge clk_i);
        n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL to_early: got err=%b at cycle 114 want 0", err_o); end
        @(negedge clk_i);
        n_cmp++; if ({eot_o, err_o} !== 2'b01) begin n_err++; $display("FAIL to_err: got eot/err %b at cycle 115 want 01", {eot_o, err_o}); end
        n_cmp++; if (status_o !== 16'h0001 || rsp_data_o !== 128'h0) begin n_err++; $display("FAIL to_status: got %h rsp %h want 0001 0", status_o, rsp_data_o); end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_r136();
        logic [47:0] fr;
        logic ok, ge, gr;
        logic [119:0] cid;
        logic [6:0] c;
        logic [135:0] good, bad;
        cid  = 120'h03_5344_5344_3136_4780_1234_5678_0142;
        c    = tb_crc7({8'h0, cid}, 120);
        good = {8'h3F, cid, c, 1'b1};
        bad  = {8'h3F, cid, c ^ 7'h05, 1'b1};
        issue(6'd2, 32'h0, 3'd3, 20'd0, fr, ok);
        n_cmp++; if (fr[47:40] !== 8'h42) begin n_err++; $display("FAIL cmd2_hdr: got %h want 42", fr[47:40]); end
        send_resp(bad, 136);
        wait_pulse(10, ge, gr);
        n_cmp++; if ({ge, gr} !== 2'b01 || status_o[3:0] !== 4'b0010) begin n_err++; $display("FAIL r136_badcrc: got eot/err %b status %h want 01 xxx2", {ge, gr}, status_o); end
        repeat (2) @(negedge clk_i);
        issue(6'd2, 32'h0, 3'd3, 20'd0, fr, ok);
        send_resp(good, 136);
        wait_pulse(10, ge, gr);
        n_cmp++; if ({ge, gr} !== 2'b10 || status_o[3:0] !== 4'b0000) begin n_err++; $display("FAIL r136_good: got eot/err %b status %h want 10 xxx0", {ge, gr}, status_o); end
        n_cmp++; if (rsp_data_o !== good[127:0]) begin n_err++; $display("FAIL r136_data: got %h want %h", rsp_data_o, good[127:0]); end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_busy();
        logic [47:0] fr;
        logic ok, ge, gr;
        logic [39:0] body;
        logic [47:0] r1;
        int early;
        body = {2'b00, 6'd7, 32'h0000_0700};
        r1   = {body, tb_crc7({88'h0, body}, 40), 1'b1};
        // DAT0 low 300 cycles, generous timeout
        issue(6'd7, 32'h1234_0000, 3'd4, 20'd1000, fr, ok);
        sddat0_i = 1'b0;
        send_resp({88'h0, r1}, 48);
        early = 0;
        for (int i = 0; i < 300; i++) begin
            if (eot_o || err_o) early++;
            @(negedge clk_i);
        end
        n_cmp++; if (early !== 0 || busy_o !== 1'b1) begin n_err++; $display("FAIL busy_hold: got early=%0d busy=%b want 0 1", early, busy_o); end
        sddat0_i = 1'b1;
        wait_pulse(10, ge, gr);
        n_cmp++; if ({ge, gr} !== 2'b10 || status_o !== 16'h0700) begin n_err++; $display("FAIL busy_eot: got eot/err %b status %h want 10 0700", {ge, gr}, status_o); end
        repeat (2) @(negedge clk_i);
        // Same, timeout of 100 cycles
        issue(6'd7, 32'h1234_0000, 3'd4, 20'd100, fr, ok);
        sddat0_i = 1'b0;
        send_resp({88'h0, r1}, 48);
        wait_pulse(400, ge, gr);
        n_cmp++; if ({ge, gr} !== 2'b01 || status_o !== 16'h0708) begin n_err++; $display("FAIL busy_to: got eot/err %b status %h want 01 0708", {ge, gr}, status_o); end
        repeat (3) @(negedge clk_i);
        sddat0_i = 1'b1;
        n_cmp++; if (status_o !== 16'h0708 || busy_o !== 1'b0) begin n_err++; $display("FAIL busy_hold_status: got %h busy %b want 0708 0", status_o, busy_o); end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_restart_reset();
        logic [18:0] cap;
        logic [18:0] exp_bits;
        int pulses;
        logic oen_bad, busy_bad;
        exp_bits = {2'b01, 6'd17, 11'h7FF};
        @(negedge clk_i);
        cmd_op_i = 6'd17; cmd_arg_i = 32'hFFFF_FFFF; rsp_type_i = 3'd1; busy_timeout_i = 20'd0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int cyc = 1; cyc < 20; cyc++) begin
            cap[19 - cyc] = sdcmd_o;
            if (cyc == 5) begin
                start_i = 1'b1; cmd_op_i = 6'd63; cmd_arg_i = 32'h0;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
        end
        start_i = 1'b0;
        n_cmp++; if (cap !== exp_bits) begin n_err++; $display("FAIL restart_ignored: got %b want %b", cap, exp_bits); end
        rstn_i = 1'b0;
        #1;
        n_cmp++; if ({sdcmd_o, sdcmd_oen_o, eot_o, err_o, busy_o} !== 5'b11000 || dbg_state_o !== 6'b000001) begin n_err++; $display("FAIL async_reset: got %b dbg %b want 11000 000001", {sdcmd_o, sdcmd_oen_o, eot_o, err_o, busy_o}, dbg_state_o); end
        n_cmp++; if (status_o !== 16'h0 || rsp_data_o !== 128'h0) begin n_err++; $display("FAIL async_reset_data: got %h %h want 0 0", status_o, rsp_data_o); end
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        pulses = 0; oen_bad = 1'b0; busy_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (eot_o || err_o) pulses++;
            if (sdcmd_oen_o !== 1'b1) oen_bad = 1'b1;
            if (busy_o !== 1'b0) busy_bad = 1'b1;
        end
        n_cmp++; if (pulses !== 0 || oen_bad !== 1'b0 || busy_bad !== 1'b0) begin n_err++; $display("FAIL post_reset_quiet: got pulses=%0d oen_bad=%b busy_bad=%b want 0 0 0", pulses, oen_bad, busy_bad); end
    endtask

    initial begin
        rstn_i = 1'b0; start_i = 1'b0; cmd_op_i = 6'd0; cmd_arg_i = 32'h0;
        rsp_type_i = 3'd0; busy_timeout_i = 20'd0; sddat0_i = 1'b1; sdcmd_i = 1'b1;
        test_reset();
        test_cmd0();
        test_cmd8();
        test_rsp_timeout();
        test_r136();
        test_busy();
        test_restart_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
